cs_window: RTL and testbench

CS_WINDOW -- requirements
Module: cs_window

---
 rtl/cs_window.sv | 160 ++++++++++++++++
 tb/tb_cs_window.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cs_window.sv
`default_nettype none
// ============================================================================
//  Module   : cs_window
//  Purpose  : Sliding-window "closest sample" filter. Keeps the last DEPTH
//             accepted samples and their running sum S, picks a window sample
//             Xa relative to the window average (largest not above it, or
//             nearest to it), and outputs Y = (S + DEPTH*Xa) >> SHIFT.
//  Ports    : clk       - clock, all state on rising edge
//             reset     - asynchronous active-low reset
//             X         - unsigned input sample (W bits)
//             in_valid  - X accepted on a rising edge while high
//             mode      - 0: largest sample <= average, 1: nearest to average
//             flush     - synchronous window clear (drops in-flight results)
//             Y         - registered result (OW bits), holds when not valid
//             out_valid - one-cycle strobe per result
//  Revision : 1.0 - initial release
// ============================================================================
module cs_window #(
    parameter int W     = 8,
    parameter int DEPTH = 9,
    parameter int SHIFT = 3,
    localparam int OW   = W + $clog2(2 * DEPTH) - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  X,
    input  logic          in_valid,
    input  logic          mode,
    input  logic          flush,
    output logic [OW-1:0] Y,
    output logic          out_valid
);

    localparam int SW   = W + $clog2(DEPTH);      // running sum / DEPTH*x width
    localparam int TW   = W + $clog2(2 * DEPTH);  // S + DEPTH*Xa width
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Window state
    // ------------------------------------------------------------------
    logic [W-1:0]    r_win [DEPTH];
    logic [PTRW-1:0] r_wptr;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_sum;

    // Pipeline: stage 1 marks "window after this edge is a full result",
    // stage 2 holds S + DEPTH*Xa, output stage holds Y.
    logic            r_v1;
    logic            r_mode1;
    logic            r_v2;
    logic [TW-1:0]   r_tot;
    logic [OW-1:0]   r_y;
    logic            r_ov;

    logic            w_fills;
    logic [PTRW-1:0] w_wptr_nxt;
    logic [W-1:0]    w_xa;
    logic [SW-1:0]   w_prod;
    logic [SW-1:0]   w_dist;
    logic [SW-1:0]   w_best_d;
    logic [TW-1:0]   w_tot;

    // The accepted sample completes (or keeps) a full window.
    assign w_fills    = (r_cnt == CW'(DEPTH)) || (r_cnt == CW'(DEPTH - 1));
    assign w_wptr_nxt = (r_wptr == PTRW'(DEPTH - 1)) ? '0 : r_wptr + PTRW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_win[i] <= '0;
            end
            r_wptr <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
        end else if (flush) begin
            // Clear first, then the concurrent sample (if any) opens the new window.
            for (int i = 0; i < DEPTH; i++) begin
                r_win[i] <= '0;
            end
            if (in_valid) begin
                r_win[0] <= X;
                r_wptr   <= PTRW'(1);
                r_cnt    <= CW'(1);
                r_sum    <= SW'(X);
            end else begin
                r_wptr   <= '0;
                r_cnt    <= '0;
                r_sum    <= '0;
            end
        end else if (in_valid) begin
            // Slots not yet filled are zero, so eviction is uniform.
            r_win[r_wptr] <= X;
            r_sum         <= r_sum + SW'(X) - SW'(r_win[r_wptr]);
            r_wptr        <= w_wptr_nxt;
            if (r_cnt != CW'(DEPTH)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Xa search over the window as it stands after the accepting edge.
    // Compares DEPTH*x against S so no divider is needed.
    // ------------------------------------------------------------------
    always_comb begin
        w_xa     = '0;
        w_prod   = '0;
        w_dist   = '0;
        w_best_d = '1;
        for (int i = 0; i < DEPTH; i++) begin
            w_prod = SW'(DEPTH) * SW'(r_win[i]);
            w_dist = (w_prod >= r_sum) ? (w_prod - r_sum) : (r_sum - w_prod);
            if (!r_mode1) begin
                if ((w_prod <= r_sum) && (r_win[i] > w_xa)) begin
                    w_xa = r_win[i];
                end
            end else begin
                if ((i == 0) || (w_dist < w_best_d) ||
                    ((w_dist == w_best_d) && (r_win[i] < w_xa))) begin
                    w_best_d = w_dist;
                    w_xa     = r_win[i];
                end
            end
        end
    end

    assign w_tot = TW'(r_sum) + TW'(SW'(DEPTH) * SW'(w_xa));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_mode1 <= 1'b0;
            r_v2    <= 1'b0;
            r_tot   <= '0;
            r_y     <= '0;
            r_ov    <= 1'b0;
        end else begin
            // A flushed window holds at most one sample, never a result.
            r_v1 <= in_valid && !flush && w_fills;
            if (in_valid) begin
                r_mode1 <= mode;
            end
            // Flush kills the result that would otherwise surface next cycle.
            r_v2 <= r_v1 && !flush;
            if (r_v1) begin
                r_tot <= w_tot;
            end
            r_ov <= r_v2;
            if (r_v2) begin
                r_y <= OW'(r_tot >> SHIFT);
            end
        end
    end

    assign Y         = r_y;
    assign out_valid = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_cs_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cs_window
//  Purpose  : Self-checking bench for cs_window. Stimulus pushes expected
//             results (with their due edge) into a scoreboard queue; a
//             monitor pops and compares whenever out_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cs_window;

    localparam int W     = 8;
    localparam int DEPTH = 9;
    localparam int SHIFT = 3;
    localparam int OW    = W + $clog2(2 * DEPTH) - SHIFT;

    typedef struct {
        int due;
        int y;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  X = '0;
    logic          in_valid = 1'b0;
    logic          mode = 1'b0;
    logic          flush = 1'b0;
    logic [OW-1:0] Y;
    logic          out_valid;

    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    exp_t q[$];
    int   win[$];

    cs_window #(.W(W), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .in_valid  (in_valid),
        .mode      (mode),
        .flush     (flush),
        .Y         (Y),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: average rule evaluated directly over the sample list.
    function automatic int ref_y(input logic m);
        int s, best, bd, d;
        s = 0;
        foreach (win[i]) s += win[i];
        best = -1;
        bd   = 1 << 30;
        foreach (win[i]) begin
            if (!m) begin
                if (DEPTH * win[i] <= s && win[i] > best) best = win[i];
            end else begin
                d = DEPTH * win[i] - s;
                if (d < 0) d = -d;
                if (d < bd || (d == bd && win[i] < best)) begin
                    bd   = d;
                    best = win[i];
                end
            end
        end
        return (s + DEPTH * best) >> SHIFT;
    endfunction

    task automatic model_edge(input logic v, input int x, input logic m,
                              input logic f, input int k);
        exp_t e;
        if (f) begin
            win.delete();
            while (q.size() > 0 && q[$].due > k) void'(q.pop_back());
        end
        if (v) begin
            win.push_back(x);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win.size() == DEPTH) begin
                e.due = k + 2;
                e.y   = ref_y(m);
                q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic v, input int x, input logic m, input logic f);
        @(negedge clk);
        in_valid = v;
        X        = W'(x);
        mode     = m;
        flush    = f;
        model_edge(v, x, m, f, edge_cnt + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_y(input string name, input int exp);
        tests++;
        if (Y !== OW'(exp)) begin
            fails++;
            $display("FAIL %s: Y=%0h expected %0h", name, Y, exp);
        end
    endtask

    task automatic check_ov0(input string name);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s: out_valid=%b expected 0", name, out_valid);
        end
    endtask

    // Monitor: compares every out_valid pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: edge=%0d Y=%0h expected no result",
                             edge_cnt, Y);
                end else begin
                    e = q.pop_front();
                    if (e.due != edge_cnt || Y !== OW'(e.y)) begin
                        fails++;
                        $display("FAIL result: edge=%0d Y=%0h expected edge=%0d Y=%0h",
                                 edge_cnt, Y, e.due, e.y);
                    end
                end
            end else if (out_valid !== 1'b0 || (q.size() > 0 && q[0].due <= edge_cnt)) begin
                tests++;
                fails++;
                $display("FAIL missing_result: edge=%0d out_valid=%b expected Y=%0h",
                         edge_cnt, out_valid, (q.size() > 0) ? q[0].y : 0);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
    end

    initial begin
        int pat[9];
        // Reset state
        repeat (3) @(negedge clk);
        check_y("reset_y", 0);
        check_ov0("reset_ov");
        reset = 1'b1;

        // Nine 0x0A, mode 0
        for (int i = 0; i < 9; i++) drive(1'b1, 8'h0A, 1'b0, 1'b0);
        idle(3);
        check_y("const_0a", 'h016);

        // Ramp 1..9 then 10
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) drive(1'b1, i, 1'b0, 1'b0);
        idle(3);
        check_y("ramp_1_9", 'h00B);
        drive(1'b1, 10, 1'b0, 1'b0);
        idle(3);
        check_y("ramp_2_10", 'h00D);

        // Skewed window, both modes
        pat = '{0, 0, 0, 0, 9, 9, 9, 9, 9};
        for (int m = 0; m < 2; m++) begin
            drive(1'b0, 0, 1'b0, 1'b1);
            for (int i = 0; i < 9; i++) drive(1'b1, pat[i], m[0], 1'b0);
            idle(3);
            check_y(m == 0 ? "skew_mode0" : "skew_mode1", m == 0 ? 'h005 : 'h00F);
        end

        // Full scale with a bubble inside the result stream
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        idle(3);
        check_y("full_scale", 'h23D);

        // Flush with valid on the 5th sample; window restarts there
        for (int i = 0; i < 4; i++) drive(1'b1, 20 + i, 1'b0, 1'b0);
        drive(1'b1, 8'h0A, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h0A, 1'b0, 1'b0);
        idle(3);
        check_y("flush_refill", 'h016);

        // Mid-stream reset with results in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h40 + i, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        win.delete();
        #1;
        check_y("async_reset_y", 0);
        check_ov0("async_reset_ov");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h0A, 1'b0, 1'b0);
        idle(3);
        check_y("reset_partial_hold", 0);
        drive(1'b1, 8'h0A, 1'b0, 1'b0);
        idle(3);
        check_y("reset_refill", 'h016);

        // Randomized traffic, small-range bursts to provoke ties
        for (int i = 0; i < 500; i++) begin
            logic v, f, m, nar;
            int   x;
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 40) == 0);
            m   = 1'($urandom_range(0, 1));
            nar = ((i / 60) % 2 == 1);
            x   = nar ? $urandom_range(0, 7) : $urandom_range(0, 255);
            drive(v, x, m, f);
        end
        idle(5);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
